ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Two-requester front end that sits directly upstream of the single-port synchronous RAM (RAM_sync: registered read, one-cycle read latency, write on `we`).
- Port 0 is the read-only video scan port and has priority. Port 1 is the CPU read/write port, with a starvation guard.
- Drives the RAM's addr/din/we each cycle and returns read data to the requester that issued the read, tagged with a per-port valid strobe.

Parameters:
- A, 10: address width in bits.
- D, 8: data width in bits.
- STARVE, 4: number of consecutive cycles port 1 may be refused before it is forced through ahead of port 0. Legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- p0_req  in  1  video read request.
- p0_addr  in  A  video read address.
- p0_ready  out  1  video request accepted this cycle.
- p0_rdata  out  D  video read data; meaningful only while p0_rvalid=1.
- p0_rvalid  out  1  p0_rdata valid; one-cycle pulse per accepted read.
- p1_valid  in  1  CPU request valid.
- p1_we  in  1  CPU request is a write (1) or a read (0).
- p1_addr  in  A  CPU address.
- p1_din  in  D  CPU write data.
- p1_ready  out  1  CPU request accepted this cycle.
- p1_rdata  out  D  CPU read data; meaningful only while p1_rvalid=1.
- p1_rvalid  out  1  p1_rdata valid; one-cycle pulse per accepted read.
- ram_addr  out  A  to RAM addr.
- ram_din  out  D  to RAM din.
- ram_we  out  1  to RAM we.
- ram_dout  in  D  from RAM dout (registered in the RAM).

Behaviour:
- **State.**
  - wait_cnt: 4-bit counter, saturates at STARVE.
  - rv0, rv1: read-valid flags.
  - On reset=0 (asynchronous), all three clear to 0.
- **Grant** (combinational, from current inputs and wait_cnt):
  - force1 = (wait_cnt >= STARVE).
  - g1 = p1_valid & (~p0_req | force1).
  - g0 = p0_req & ~g1.
  - At most one grant per cycle.
- **Ready outputs:**
  - p0_ready = g0 and p1_ready = g1.
  - Both are forced to 0 while reset=0.
- **RAM drive** (combinational):
  - If g1: ram_addr = p1_addr, ram_we = p1_we.
  - Else: ram_addr = p0_addr, ram_we = 0.
  - ram_din = p1_din always.
  - ram_we is never 1 unless g1 & p1_we; it is 0 during reset.
- **Handshake.**
  - A transfer occurs on the edge where valid/req and ready are both 1.
  - Requesters hold addr/din/we stable while valid and not ready.
  - The arbiter does not buffer requests.
- **Read latency.**
  - rv0 <= g0 and rv1 <= g1 & ~p1_we.
  - p0_rvalid = rv0 and p1_rvalid = rv1, so each pulses exactly one cycle after acceptance.
  - p0_rdata = p1_rdata = ram_dout (pass-through). ram_dout is valid in that cycle because of the RAM's one-cycle latency.
  - Back-to-back accepted reads produce back-to-back rvalid pulses. Throughput is 1 access per cycle.
- **Write-then-read, same address, consecutive cycles.**
  - The read returns the new data, because the RAM has already stored it by the read edge.
  - A read in the same cycle as a write is impossible (single grant).
- **Starvation counter**, evaluated at the edge:
  - If g1 or ~p1_valid: wait_cnt <= 0.
  - Else if wait_cnt < STARVE: wait_cnt <= wait_cnt + 1.
  - Else: hold.
  - Effect: with p0_req stuck high, port 1 is granted on the (STARVE+1)-th cycle of waiting, then the counter restarts.
- **Port 0 under starvation.** Port 0 loses exactly that one cycle and retries. Its request is not dropped; p0_ready is simply 0.
- **Reset mid-operation.**
  - Pending rvalid pulses are cancelled.
  - wait_cnt clears.
  - RAM contents are not touched; no write issues while reset=0.
- **Idle** (no requests): ready=0, ram_we=0, rvalid=0 the following cycle.

Test Plan:
- **Reset:** assert reset=0 mid-stream with rv1 pending -> p1_rvalid, p0_rvalid, ram_we, and both readies are 0 immediately; after release, the first accepted read produces rvalid exactly 1 cycle later.
- **CPU write then read:** p1 write addr 0x05 data 0xA5, then read 0x05 on the next cycle -> p1_ready=1 both cycles; p1_rvalid pulses once, one cycle after the read, with p1_rdata=0xA5; no rvalid for the write.
- **Priority:** p0_req and p1_valid both high for 1 cycle, STARVE=4 -> p0_ready=1, p1_ready=0; ram_addr=p0_addr, ram_we=0; p0_rvalid=1 next cycle.
- **Starvation:** p0_req held high continuously, p1_valid high from cycle 0 -> p1_ready=0 for cycles 0-3 and 1 in cycle 4; p0_ready=0 only in cycle 4; p1_ready=0 again in cycles 5-8.
- **Streaming:** p0 reads addresses 0..7 on consecutive cycles, no CPU traffic; RAM preloaded with mem[i]=i^0x3C -> eight consecutive p0_rvalid pulses with rdata 0x3C,0x3D,0x3E,0x3F,0x38,0x39,0x3A,0x3B.
- **Interleave:** CPU writes 0x10=0x77 while p0 reads 0x10 in the same cycle, then p0 reads 0x10 again -> first p0 read returns the old value and the CPU write is stalled one cycle (p1_ready=0), so the second p0 read, if issued after the write is granted, returns 0x77.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// Bundle of the two requester ports and the RAM-side bus for ram_port_arbiter.
// No logic, so latency does not apply.
// Valid/ready handshake lives here; the arbiter never buffers a request.
interface ram_port_arbiter_if #(
    parameter int A = 10,
    parameter int D = 8
);
    // video scan port (read only)
    logic         p0_req;
    logic [A-1:0] p0_addr;
    logic         p0_ready;
    logic [D-1:0] p0_rdata;
    logic         p0_rvalid;
    // CPU port (read/write)
    logic         p1_valid;
    logic         p1_we;
    logic [A-1:0] p1_addr;
    logic [D-1:0] p1_din;
    logic         p1_ready;
    logic [D-1:0] p1_rdata;
    logic         p1_rvalid;
    // RAM side
    logic [A-1:0] ram_addr;
    logic [D-1:0] ram_din;
    logic         ram_we;
    logic [D-1:0] ram_dout;

    modport slave (
        input  p0_req, p0_addr, p1_valid, p1_we, p1_addr, p1_din, ram_dout,
        output p0_ready, p0_rdata, p0_rvalid, p1_ready, p1_rdata, p1_rvalid,
               ram_addr, ram_din, ram_we
    );

    modport master (
        output p0_req, p0_addr, p1_valid, p1_we, p1_addr, p1_din, ram_dout,
        input  p0_ready, p0_rdata, p0_rvalid, p1_ready, p1_rdata, p1_rvalid,
               ram_addr, ram_din, ram_we
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-port front end for a single-port synchronous RAM; video port wins unless the CPU has starved.
// Grant/RAM drive is combinational; read data returns with rvalid one cycle after acceptance.
// Loser sees ready=0 and must hold its request; nothing is buffered, so throughput is one access per cycle.
module ram_port_arbiter #(
    parameter int A      = 10,
    parameter int D      = 8,
    parameter int STARVE = 4
) (
    input logic              clk,
    input logic              reset,
    ram_port_arbiter_if.slave bus
);
    localparam logic [3:0] STARVE_C = 4'(STARVE);

    logic [3:0]   wait_q, wait_d;
    logic         rv0_q, rv0_d;
    logic         rv1_q, rv1_d;
    logic         force1;
    logic         g0, g1;
    logic [A-1:0] addr_mux;
    logic [D-1:0] din_mux;

    // Single grant per cycle: CPU only when video is idle or CPU has waited STARVE cycles.
    // Grants are gated by reset so nothing is accepted or written while in reset.
    always_comb begin
        force1 = (wait_q >= STARVE_C);
        g1     = reset & bus.p1_valid & (~bus.p0_req | force1);
        g0     = reset & bus.p0_req & ~g1;
    end

    // RAM address follows the granted port; the video port is the idle default.
    always_comb begin
        addr_mux = g1 ? bus.p1_addr : bus.p0_addr;
        din_mux  = bus.p1_din;
    end

    assign bus.p0_ready  = g0;
    assign bus.p1_ready  = g1;
    assign bus.ram_addr  = addr_mux;
    assign bus.ram_din   = din_mux;
    assign bus.ram_we    = g1 & bus.p1_we;
    assign bus.p0_rvalid = rv0_q;
    assign bus.p1_rvalid = rv1_q;
    assign bus.p0_rdata  = bus.ram_dout;
    assign bus.p1_rdata  = bus.ram_dout;

    // Starvation counter restarts on a CPU grant or when the CPU stops asking; saturates at STARVE.
    // Read-valid flags mark which port owns the RAM output on the next cycle.
    always_comb begin
        wait_d = wait_q;
        if (g1 || !bus.p1_valid) begin
            wait_d = '0;
        end else if (wait_q < STARVE_C) begin
            wait_d = wait_q + 4'd1;
        end
        rv0_d = g0;
        rv1_d = g1 & ~bus.p1_we;
    end

    // State registers; reset cancels any pending read return.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_q <= '0;
            rv0_q  <= 1'b0;
            rv1_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            rv0_q  <= rv0_d;
            rv1_q  <= rv1_d;
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural one-cycle-latency RAM behind it.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// Each scenario task compares against hand-computed values and counts passes.
module tb_ram_port_arbiter;
    logic clk;
    logic reset;
    int   pass_cnt;
    int   total_cnt;
    logic [7:0] mem [0:1023];

    ram_port_arbiter_if #(.A(10), .D(8)) bus ();

    ram_port_arbiter #(.A(10), .D(8), .STARVE(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous RAM: write on we, registered read of the old contents
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_addr];
    end

    task automatic idle();
        bus.p0_req   = 1'b0;
        bus.p1_valid = 1'b0;
        bus.p1_we    = 1'b0;
    endtask

    task automatic cpu_write(input logic [9:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.p0_req = 1'b0; bus.p1_valid = 1'b1; bus.p1_we = 1'b1;
        bus.p1_addr = a; bus.p1_din = d;
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.p0_req = 1'b1; bus.p0_addr = 10'h0;
        bus.p1_valid = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 10'h3; bus.p1_din = 8'h00;
        #1;
        total_cnt++; if (bus.p0_ready !== 1'b0) $display("FAIL rst_p0_ready: got %b want 0", bus.p0_ready); else pass_cnt++;
        total_cnt++; if (bus.p1_ready !== 1'b0) $display("FAIL rst_p1_ready: got %b want 0", bus.p1_ready); else pass_cnt++;
        total_cnt++; if (bus.ram_we !== 1'b0) $display("FAIL rst_ram_we: got %b want 0", bus.ram_we); else pass_cnt++;
        total_cnt++; if (bus.p0_rvalid !== 1'b0 || bus.p1_rvalid !== 1'b0) $display("FAIL rst_rvalid: got %b%b want 00", bus.p0_rvalid, bus.p1_rvalid); else pass_cnt++;
        @(negedge clk);
        reset = 1'b1; idle();
        // CPU read accepted, then reset lands while its rvalid is pending
        @(negedge clk);
        bus.p1_valid = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 10'h3;
        #1;
        total_cnt++; if (bus.p1_ready !== 1'b1) $display("FAIL rst_pre_read_ready: got %b want 1", bus.p1_ready); else pass_cnt++;
        @(posedge clk);
        #1;
        reset = 1'b0; bus.p1_we = 1'b1; bus.p0_req = 1'b1;
        #1;
        total_cnt++; if (bus.p1_rvalid !== 1'b0) $display("FAIL rst_mid_p1_rvalid: got %b want 0", bus.p1_rvalid); else pass_cnt++;
        total_cnt++; if (bus.ram_we !== 1'b0) $display("FAIL rst_mid_ram_we: got %b want 0", bus.ram_we); else pass_cnt++;
        total_cnt++; if (bus.p0_ready !== 1'b0 || bus.p1_ready !== 1'b0) $display("FAIL rst_mid_ready: got %b%b want 00", bus.p0_ready, bus.p1_ready); else pass_cnt++;
        total_cnt++; if (bus.p0_rvalid !== 1'b0) $display("FAIL rst_mid_p0_rvalid: got %b want 0", bus.p0_rvalid); else pass_cnt++;
        @(negedge clk);
        reset = 1'b1; idle();
        @(negedge clk);
        bus.p0_req = 1'b1; bus.p0_addr = 10'h0;
        #1;
        total_cnt++; if (bus.p0_ready !== 1'b1) $display("FAIL rst_post_p0_ready: got %b want 1", bus.p0_ready); else pass_cnt++;
        total_cnt++; if (bus.p0_rvalid !== 1'b0) $display("FAIL rst_post_early_rvalid: got %b want 0", bus.p0_rvalid); else pass_cnt++;
        @(negedge clk);
        idle();
        #1;
        total_cnt++; if (bus.p0_rvalid !== 1'b1) $display("FAIL rst_post_rvalid: got %b want 1", bus.p0_rvalid); else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++; if (bus.p0_rvalid !== 1'b0) $display("FAIL rst_post_rvalid_end: got %b want 0", bus.p0_rvalid); else pass_cnt++;
    endtask

    task automatic test_write_read();
        @(negedge clk);
        bus.p1_valid = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 10'h05; bus.p1_din = 8'hA5;
        #1;
        total_cnt++; if (bus.p1_ready !== 1'b1) $display("FAIL wr_ready: got %b want 1", bus.p1_ready); else pass_cnt++;
        total_cnt++; if (bus.ram_we !== 1'b1) $display("FAIL wr_ram_we: got %b want 1", bus.ram_we); else pass_cnt++;
        total_cnt++; if (bus.ram_addr !== 10'h05 || bus.ram_din !== 8'hA5) $display("FAIL wr_ram_bus: got %h/%h want 005/a5", bus.ram_addr, bus.ram_din); else pass_cnt++;
        @(negedge clk);
        bus.p1_we = 1'b0;
        #1;
        total_cnt++; if (bus.p1_ready !== 1'b1) $display("FAIL rd_ready: got %b want 1", bus.p1_ready); else pass_cnt++;
        total_cnt++; if (bus.ram_we !== 1'b0) $display("FAIL rd_ram_we: got %b want 0", bus.ram_we); else pass_cnt++;
        total_cnt++; if (bus.p1_rvalid !== 1'b0) $display("FAIL wr_no_rvalid: got %b want 0", bus.p1_rvalid); else pass_cnt++;
        @(negedge clk);
        idle();
        #1;
        total_cnt++; if (bus.p1_rvalid !== 1'b1) $display("FAIL rd_rvalid: got %b want 1", bus.p1_rvalid); else pass_cnt++;
        total_cnt++; if (bus.p1_rdata !== 8'hA5) $display("FAIL rd_rdata: got %h want a5", bus.p1_rdata); else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++; if (bus.p1_rvalid !== 1'b0) $display("FAIL rd_rvalid_end: got %b want 0", bus.p1_rvalid); else pass_cnt++;
    endtask

    task automatic test_priority();
        @(negedge clk);
        bus.p0_req = 1'b1; bus.p0_addr = 10'h05;
        bus.p1_valid = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 10'h20; bus.p1_din = 8'h11;
        #1;
        total_cnt++; if (bus.p0_ready !== 1'b1 || bus.p1_ready !== 1'b0) $display("FAIL pri_ready: got p0=%b p1=%b want p0=1 p1=0", bus.p0_ready, bus.p1_ready); else pass_cnt++;
        total_cnt++; if (bus.ram_addr !== 10'h05) $display("FAIL pri_ram_addr: got %h want 005", bus.ram_addr); else pass_cnt++;
        total_cnt++; if (bus.ram_we !== 1'b0) $display("FAIL pri_ram_we: got %b want 0", bus.ram_we); else pass_cnt++;
        @(negedge clk);
        idle();
        #1;
        total_cnt++; if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== 8'hA5) $display("FAIL pri_rvalid: got %b/%h want 1/a5", bus.p0_rvalid, bus.p0_rdata); else pass_cnt++;
        total_cnt++; if (bus.p1_rvalid !== 1'b0) $display("FAIL pri_p1_rvalid: got %b want 0", bus.p1_rvalid); else pass_cnt++;
    endtask

    task automatic test_starvation();
        logic exp1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            bus.p0_req = 1'b1; bus.p0_addr = 10'h01;
            bus.p1_valid = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 10'h05;
            #1;
            exp1 = (k == 4);
            total_cnt++; if (bus.p1_ready !== exp1) $display("FAIL starve_p1_ready[%0d]: got %b want %b", k, bus.p1_ready, exp1); else pass_cnt++;
            total_cnt++; if (bus.p0_ready !== ~exp1) $display("FAIL starve_p0_ready[%0d]: got %b want %b", k, bus.p0_ready, ~exp1); else pass_cnt++;
            if (k == 5) begin
                total_cnt++; if (bus.p1_rvalid !== 1'b1 || bus.p1_rdata !== 8'hA5) $display("FAIL starve_p1_rvalid: got %b/%h want 1/a5", bus.p1_rvalid, bus.p1_rdata); else pass_cnt++;
                total_cnt++; if (bus.p0_rvalid !== 1'b0) $display("FAIL starve_p0_rvalid: got %b want 0", bus.p0_rvalid); else pass_cnt++;
            end
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_streaming();
        logic [7:0] exp_tab [0:7];
        exp_tab[0] = 8'h3C; exp_tab[1] = 8'h3D; exp_tab[2] = 8'h3E; exp_tab[3] = 8'h3F;
        exp_tab[4] = 8'h38; exp_tab[5] = 8'h39; exp_tab[6] = 8'h3A; exp_tab[7] = 8'h3B;
        for (int i = 0; i < 8; i++) begin
            cpu_write(10'(i), 8'(i) ^ 8'h3C);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k < 8) begin
                bus.p0_req = 1'b1; bus.p0_addr = 10'(k);
            end else begin
                idle();
            end
            #1;
            if (k < 8) begin
                total_cnt++; if (bus.p0_ready !== 1'b1) $display("FAIL stream_ready[%0d]: got %b want 1", k, bus.p0_ready); else pass_cnt++;
            end
            if (k >= 1 && k <= 8) begin
                total_cnt++; if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== exp_tab[k-1]) $display("FAIL stream_rdata[%0d]: got %b/%h want 1/%h", k-1, bus.p0_rvalid, bus.p0_rdata, exp_tab[k-1]); else pass_cnt++;
            end
            if (k == 9) begin
                total_cnt++; if (bus.p0_rvalid !== 1'b0) $display("FAIL stream_rvalid_end: got %b want 0", bus.p0_rvalid); else pass_cnt++;
            end
        end
    endtask

    task automatic test_interleave();
        cpu_write(10'h10, 8'h11);
        @(negedge clk);
        bus.p0_req = 1'b1; bus.p0_addr = 10'h10;
        bus.p1_valid = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 10'h10; bus.p1_din = 8'h77;
        #1;
        total_cnt++; if (bus.p0_ready !== 1'b1 || bus.p1_ready !== 1'b0) $display("FAIL intl_first_ready: got p0=%b p1=%b want p0=1 p1=0", bus.p0_ready, bus.p1_ready); else pass_cnt++;
        @(negedge clk);
        bus.p0_req = 1'b0;
        #1;
        total_cnt++; if (bus.p1_ready !== 1'b1 || bus.ram_we !== 1'b1) $display("FAIL intl_write_grant: got ready=%b we=%b want 1/1", bus.p1_ready, bus.ram_we); else pass_cnt++;
        total_cnt++; if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== 8'h11) $display("FAIL intl_old_data: got %b/%h want 1/11", bus.p0_rvalid, bus.p0_rdata); else pass_cnt++;
        @(negedge clk);
        bus.p1_valid = 1'b0; bus.p1_we = 1'b0;
        bus.p0_req = 1'b1; bus.p0_addr = 10'h10;
        #1;
        total_cnt++; if (bus.p0_ready !== 1'b1 || bus.p0_rvalid !== 1'b0) $display("FAIL intl_second_read: got ready=%b rvalid=%b want 1/0", bus.p0_ready, bus.p0_rvalid); else pass_cnt++;
        @(negedge clk);
        idle();
        #1;
        total_cnt++; if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== 8'h77) $display("FAIL intl_new_data: got %b/%h want 1/77", bus.p0_rvalid, bus.p0_rdata); else pass_cnt++;
    endtask

    task automatic test_idle();
        @(negedge clk);
        idle();
        #1;
        total_cnt++; if (bus.p0_ready !== 1'b0 || bus.p1_ready !== 1'b0 || bus.ram_we !== 1'b0) $display("FAIL idle_outputs: got r0=%b r1=%b we=%b want 000", bus.p0_ready, bus.p1_ready, bus.ram_we); else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++; if (bus.p0_rvalid !== 1'b0 || bus.p1_rvalid !== 1'b0) $display("FAIL idle_rvalid: got %b%b want 00", bus.p0_rvalid, bus.p1_rvalid); else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        bus.p0_addr = '0; bus.p1_addr = '0; bus.p1_din = '0;
        test_reset();
        test_write_read();
        test_priority();
        test_starvation();
        test_streaming();
        test_interleave();
        test_idle();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
